// File: rtl/pattern_scan_engine_pkg.sv
// rtl/pattern_scan_engine_pkg.sv - shared states, default addresses and helpers for the pattern scanner
package pattern_scan_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_PAT,
        S_SCAN,
        S_WR_CTB,
        S_WR_CTO,
        S_WR_CTS,
        S_DONE
    } state_t;

    localparam int DEF_BASE_ADDR = 0;
    localparam int DEF_NBYTES    = 32;
    localparam int DEF_PAT_ADDR  = 32;
    localparam int DEF_RES_ADDR  = 33;

    localparam int WIN_BITS = 5;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/pattern_scan_engine_pat_window_match.sv
// rtl/pattern_scan_engine_pat_window_match.sv - counts 5-bit pattern hits inside a byte and across the byte boundary
module pat_window_match
    import pattern_scan_engine_pkg::*;
(
    input  logic [4:0] pat,
    input  logic [7:0] b,
    input  logic [7:0] p,
    input  logic       first,
    output logic [2:0] in_cnt,
    output logic       any_match,
    output logic [2:0] cross_cnt
);

    // Low nibble of the previous byte glued above the current byte: windows
    // starting at offsets 0..3 lie inside b, offsets 4..7 straddle p and b.
    logic [11:0] joined;
    logic [3:0]  in_hit;
    logic [3:0]  cross_hit;

    always_comb begin
        joined    = {p[3:0], b};
        in_hit    = '0;
        cross_hit = '0;
        for (int k = 0; k < 4; k++) begin
            in_hit[k]    = (joined[k +: WIN_BITS] == pat);
            cross_hit[k] = (joined[(k + 4) +: WIN_BITS] == pat) && !first;
        end
        in_cnt    = popcount4(in_hit);
        any_match = |in_hit;
        cross_cnt = popcount4(cross_hit);
    end

endmodule

// File: rtl/pattern_scan_engine.sv
// rtl/pattern_scan_engine.sv - scans a message in data memory for a 5-bit pattern and writes three hit counts
module pattern_scan_engine
    import pattern_scan_engine_pkg::*;
#(
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int NBYTES    = DEF_NBYTES,
    parameter int PAT_ADDR  = DEF_PAT_ADDR,
    parameter int RES_ADDR  = DEF_RES_ADDR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    localparam logic [7:0] BASE8     = 8'(BASE_ADDR);
    localparam logic [7:0] PAT8      = 8'(PAT_ADDR);
    localparam logic [7:0] RES8      = 8'(RES_ADDR);
    localparam logic [7:0] LAST_IDX  = 8'(NBYTES - 1);

    state_t     state;
    state_t     next_state;
    logic [4:0] pat;
    logic [7:0] prev;
    logic [7:0] idx;
    logic [7:0] ctb;
    logic [7:0] cto;
    logic [7:0] cts;

    logic [2:0] in_cnt;
    logic       any_match;
    logic [2:0] cross_cnt;

    pat_window_match u_match (
        .pat       (pat),
        .b         (mem_rd_data),
        .p         (prev),
        .first     (idx == 8'd0),
        .in_cnt    (in_cnt),
        .any_match (any_match),
        .cross_cnt (cross_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat  <= '0;
            prev <= '0;
            idx  <= '0;
            ctb  <= '0;
            cto  <= '0;
            cts  <= '0;
        end else begin
            case (state)
                S_LOAD_PAT: begin
                    pat  <= mem_rd_data[4:0];
                    prev <= '0;
                    idx  <= '0;
                    ctb  <= '0;
                    cto  <= '0;
                    cts  <= '0;
                end
                S_SCAN: begin
                    prev <= mem_rd_data;
                    idx  <= idx + 8'd1;
                    ctb  <= ctb + {5'b00000, in_cnt};
                    cto  <= cto + {7'b0000000, any_match};
                    // cts covers every window of the whole bit string, so it
                    // takes the in-byte hits plus those straddling the boundary.
                    cts  <= cts + {5'b00000, in_cnt} + {5'b00000, cross_cnt};
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state  = state;
        ack         = 1'b0;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_LOAD_PAT;
                end
            end
            S_LOAD_PAT: begin
                mem_addr   = PAT8;
                next_state = S_SCAN;
            end
            S_SCAN: begin
                mem_addr = BASE8 + idx;
                if (idx == LAST_IDX) begin
                    next_state = S_WR_CTB;
                end
            end
            S_WR_CTB: begin
                mem_wr_en   = 1'b1;
                mem_addr    = RES8;
                mem_wr_data = ctb;
                next_state  = S_WR_CTO;
            end
            S_WR_CTO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = RES8 + 8'd1;
                mem_wr_data = cto;
                next_state  = S_WR_CTS;
            end
            S_WR_CTS: begin
                mem_wr_en   = 1'b1;
                mem_addr    = RES8 + 8'd2;
                mem_wr_data = cts;
                next_state  = S_DONE;
            end
            S_DONE: begin
                ack        = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_scan_engine.sv
// tb/tb_pattern_scan_engine.sv - self-checking bench for pattern_scan_engine
module tb_pattern_scan_engine;

    localparam int NB  = 32;
    localparam int RES = 33;

    typedef struct {
        string      name;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] rest;
        logic [7:0] pat;
        bit         rnd;
        int         ectb;
        int         ecto;
        int         ects;
    } vec_t;

    typedef struct {
        int ctb;
        int cto;
        int cts;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] msg [NB];
    logic [7:0] pat_byte;
    logic [7:0] wmem [256];
    logic       clear_res;
    int         wr_count = 0;
    int         ack_count = 0;
    int         bad_wr = 0;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[8];

    pattern_scan_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ack         (ack),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rd_data = 8'h00;
        if (mem_addr < 8'(NB)) mem_rd_data = msg[mem_addr[4:0]];
        else if (mem_addr == 8'd32) mem_rd_data = pat_byte;
        else mem_rd_data = wmem[mem_addr];
    end

    always @(posedge clk) begin
        if (clear_res) begin
            for (int a = 0; a < 256; a++) wmem[a] <= 8'hAA;
        end else if (mem_wr_en) begin
            wmem[mem_addr] <= mem_wr_data;
            wr_count <= wr_count + 1;
            if (mem_addr < 8'(RES) || mem_addr > 8'(RES + 2)) bad_wr <= bad_wr + 1;
        end
        if (ack === 1'b1) ack_count <= ack_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: slide a 5-bit window over the MSB-first bit string of the message.
    task automatic model(input logic [4:0] pt, output int ctb, output int cto, output int cts);
        bit hit [NB];
        logic [4:0] w;
        int bi;
        ctb = 0; cto = 0; cts = 0;
        for (int i = 0; i < NB; i++) hit[i] = 0;
        for (int n = 0; n <= 8 * NB - 5; n++) begin
            w = '0;
            for (int j = 0; j < 5; j++) begin
                bi = n + j;
                w = {w[3:0], msg[bi / 8][7 - (bi % 8)]};
            end
            if (w == pt) begin
                cts++;
                if (n % 8 <= 3) begin
                    ctb++;
                    hit[n / 8] = 1;
                end
            end
        end
        for (int i = 0; i < NB; i++) cto += int'(hit[i]);
    endtask

    task automatic clear_results();
        @(negedge clk) clear_res = 1'b1;
        @(negedge clk) clear_res = 1'b0;
    endtask

    task automatic run_and_check(input string name, input int ectb, input int ecto, input int ects,
                                 input int extra_at);
        exp_t e;
        int   k;
        int   wbase;
        int   abase;
        bit   got;
        clear_results();
        e.ctb = ectb; e.cto = ecto; e.cts = ects;
        sb.push_back(e);
        wbase = wr_count;
        abase = ack_count;
        got = 0;
        k = 0;
        @(negedge clk) start = 1'b1;
        while (k < 100 && !got) begin
            @(negedge clk);
            k++;
            start = (k == extra_at);
            if (ack === 1'b1) got = 1;
        end
        start = 1'b0;
        check({name, " latency"}, k, 37);
        repeat (60) @(negedge clk);
        check({name, " ack count"}, ack_count - abase, 1);
        check({name, " write count"}, wr_count - wbase, 3);
        check({name, " stray writes"}, bad_wr, 0);
        e = sb.pop_front();
        check({name, " ctb"}, wmem[RES], e.ctb);
        check({name, " cto"}, wmem[RES + 1], e.cto);
        check({name, " cts"}, wmem[RES + 2], e.cts);
    endtask

    task automatic load_vec(input vec_t v, output int ectb, output int ecto, output int ects);
        for (int i = 0; i < NB; i++) begin
            if (v.rnd) msg[i] = 8'($urandom);
            else msg[i] = (i == 0) ? v.b0 : (i == 1) ? v.b1 : v.rest;
        end
        pat_byte = v.rnd ? 8'($urandom) : v.pat;
        if (v.rnd) model(pat_byte[4:0], ectb, ecto, ects);
        else begin
            ectb = v.ectb; ecto = v.ecto; ects = v.ects;
        end
    endtask

    initial begin
        int   ectb, ecto, ects;
        int   k, k1, k2, wbase, abase;

        vecs[0] = '{"zeros",     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 128, 32, 252};
        vecs[1] = '{"alt55",     8'h55, 8'h55, 8'h55, 8'h15, 1'b0,  64, 32, 126};
        vecs[2] = '{"crossing",  8'h03, 8'hE0, 8'h00, 8'h1F, 1'b0,   0,  0,   1};
        vecs[3] = '{"pat_upper", 8'h55, 8'h55, 8'h55, 8'hF5, 1'b0,  64, 32, 126};
        vecs[4] = '{"ones",      8'hFF, 8'hFF, 8'hFF, 8'h1F, 1'b0, 128, 32, 252};
        vecs[5] = '{"rand_a",    8'h00, 8'h00, 8'h00, 8'h00, 1'b1,   0,  0,   0};
        vecs[6] = '{"rand_b",    8'h00, 8'h00, 8'h00, 8'h00, 1'b1,   0,  0,   0};
        vecs[7] = '{"rand_c",    8'h00, 8'h00, 8'h00, 8'h00, 1'b1,   0,  0,   0};

        rst_n = 1'b0;
        start = 1'b0;
        clear_res = 1'b0;
        pat_byte = 8'h00;
        for (int i = 0; i < NB; i++) msg[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset ack", ack, 0);
        check("reset wr_en", mem_wr_en, 0);
        check("reset addr", mem_addr, 0);
        check("reset wr_data", mem_wr_data, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no run without start", wr_count, 0);

        for (int v = 0; v < 8; v++) begin
            load_vec(vecs[v], ectb, ecto, ects);
            run_and_check(vecs[v].name, ectb, ecto, ects, 0);
        end

        load_vec(vecs[1], ectb, ecto, ects);
        run_and_check("start_during_run", ectb, ecto, ects, 10);

        load_vec(vecs[0], ectb, ecto, ects);
        clear_results();
        wbase = wr_count;
        abase = ack_count;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort addr", mem_addr, 0);
        check("abort wr_en", mem_wr_en, 0);
        check("abort ack", ack, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("abort writes", wr_count - wbase, 0);
        check("abort acks", ack_count - abase, 0);
        check("abort result kept", wmem[RES], 8'hAA);
        check("abort idle addr", mem_addr, 0);
        run_and_check("after_abort", 128, 32, 252, 0);

        load_vec(vecs[1], ectb, ecto, ects);
        clear_results();
        wbase = wr_count;
        k = 0; k1 = 0; k2 = 0;
        @(negedge clk) start = 1'b1;
        while (k < 200 && k2 == 0) begin
            @(negedge clk);
            k++;
            if (ack === 1'b1) begin
                if (k1 == 0) k1 = k;
                else k2 = k;
            end
        end
        start = 1'b0;
        check("held start first ack", k1, 37);
        check("held start second ack", k2 - k1, 38);
        repeat (60) @(negedge clk);
        check("held start writes", wr_count - wbase, 6);
        check("held start cts", wmem[RES + 2], 126);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
